cache_fill_arbiter: RTL and testbench

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_arbiter
// Description : Round-robin arbiter that serves cache block misses from
//               several requesters and sequences block fills from a pipelined
//               word-wide memory into the granted port's cache array.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int WORD_BYTES      = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               miss_req,
    input  logic [NUM_PORTS*ADDR_W-1:0]        miss_addr,
    output logic [NUM_PORTS-1:0]               stall,
    output logic                               mem_rd,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic                               mem_valid,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic [NUM_PORTS-1:0]               fill_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic [ADDR_W-1:0]                  fill_base,
    output logic [NUM_PORTS-1:0]               fill_done,
    output logic                               busy
);

    localparam int c_word_w = $clog2(WORDS_PER_BLOCK);
    localparam int c_cnt_w  = c_word_w + 1;
    localparam int c_port_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_off_w  = $clog2(WORDS_PER_BLOCK * WORD_BYTES);

    localparam logic [ADDR_W-1:0]   c_align_mask = {ADDR_W{1'b1}} << c_off_w;
    localparam logic [ADDR_W-1:0]   c_word_step  = ADDR_W'(WORD_BYTES);
    localparam logic [c_cnt_w-1:0]  c_words      = c_cnt_w'(WORDS_PER_BLOCK);
    localparam logic [c_cnt_w-1:0]  c_last_word  = c_cnt_w'(WORDS_PER_BLOCK - 1);
    localparam logic [c_port_w-1:0] c_last_port  = c_port_w'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_port_w-1:0]   r_grant;
    logic [c_port_w-1:0]   r_rr_ptr;
    logic [ADDR_W-1:0]     r_fill_base;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [c_cnt_w-1:0]    r_issue_cnt;
    logic [c_cnt_w-1:0]    r_rcv_cnt;

    logic                  w_any;
    logic [c_port_w-1:0]   w_sel;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [NUM_PORTS-1:0]  w_grant_oh;
    logic                  w_grant_now;
    logic                  w_accept;

    // Round-robin pick: scan a doubled request vector starting at the pointer
    // so the first hit in the window [ptr, ptr+NUM_PORTS) wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 0; k < 2 * NUM_PORTS; k++) begin
            if (!w_any && (k >= int'(r_rr_ptr)) && (k < int'(r_rr_ptr) + NUM_PORTS)
                && miss_req[k % NUM_PORTS]) begin
                w_any = 1'b1;
                w_sel = c_port_w'(k % NUM_PORTS);
            end
        end
    end

    // Miss address of the port currently winning arbitration.
    always_comb begin
        w_sel_addr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel == c_port_w'(p)) begin
                w_sel_addr = miss_addr[p*ADDR_W +: ADDR_W];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_grant_oh
        assign w_grant_oh[p] = (r_grant == c_port_w'(p));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; responses outside FILL are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_now = 1'b0;
        w_accept    = 1'b0;
        mem_rd      = 1'b0;
        fill_we     = '0;
        fill_done   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_now = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                mem_rd = (r_issue_cnt < c_words);
                if (mem_valid && (r_rcv_cnt < c_words)) begin
                    w_accept = 1'b1;
                    fill_we  = w_grant_oh;
                    if (r_rcv_cnt == c_last_word) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                fill_done   = w_grant_oh;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture, address generation and issue/receive counting. The issue
    // address stops advancing on the last word so it holds the final address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_fill_base <= '0;
            r_mem_addr  <= '0;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
        end else if (w_grant_now) begin
            r_grant     <= w_sel;
            r_rr_ptr    <= (w_sel == c_last_port) ? '0 : w_sel + c_port_w'(1);
            r_fill_base <= w_sel_addr & c_align_mask;
            r_mem_addr  <= w_sel_addr & c_align_mask;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
        end else begin
            if (mem_rd) begin
                r_issue_cnt <= r_issue_cnt + c_cnt_w'(1);
                if (r_issue_cnt != c_last_word) begin
                    r_mem_addr <= r_mem_addr + c_word_step;
                end
            end
            if (w_accept) begin
                r_rcv_cnt <= r_rcv_cnt + c_cnt_w'(1);
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign fill_base = r_fill_base;
    assign fill_word = r_rcv_cnt[c_word_w-1:0];
    assign fill_data = mem_rdata;
    assign busy      = (r_state != IDLE);
    assign stall     = miss_req & ~fill_done;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_arbiter
// Description : Self-checking bench for cache_fill_arbiter. A default 2-port
//               instance is fed by a latency-3 memory model and checked by a
//               scoreboard; a 4-port, 2-word instance with latency 1 covers
//               the parameter sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // default instance
    logic [1:0]  miss_req;
    logic [31:0] miss_addr;
    logic [1:0]  stall;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [1:0]  fill_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic [15:0] fill_base;
    logic [1:0]  fill_done;
    logic        busy;
    // sweep instance
    logic [3:0]  s_miss_req;
    logic [63:0] s_miss_addr;
    logic [3:0]  s_stall;
    logic        s_mem_rd;
    logic [15:0] s_mem_addr;
    logic        s_mem_valid;
    logic [15:0] s_mem_rdata;
    logic [3:0]  s_fill_we;
    logic [0:0]  s_fill_word;
    logic [15:0] s_fill_data;
    logic [15:0] s_fill_base;
    logic [3:0]  s_fill_done;
    logic        s_busy;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .stall(stall), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_word(fill_word),
        .fill_data(fill_data), .fill_base(fill_base), .fill_done(fill_done), .busy(busy)
    );

    cache_fill_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(16),
                         .WORDS_PER_BLOCK(2), .WORD_BYTES(2)) dut4 (
        .clk(clk), .rst(rst), .miss_req(s_miss_req), .miss_addr(s_miss_addr),
        .stall(s_stall), .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_valid(s_mem_valid),
        .mem_rdata(s_mem_rdata), .fill_we(s_fill_we), .fill_word(s_fill_word),
        .fill_data(s_fill_data), .fill_base(s_fill_base), .fill_done(s_fill_done), .busy(s_busy)
    );

    typedef struct {
        int          port;
        int          word;
        logic [15:0] base;
        logic [15:0] data;
    } fill_t;

    fill_t       fill_q[$];
    logic [15:0] iss_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic        pv [0:7];
    logic [15:0] pa [0:7];
    logic        sv [0:7];
    logic [15:0] sa [0:7];
    logic        stray;
    logic        done_due;
    int          done_port;
    int          rcv_in_fill;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input int port, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            iss_q.push_back(base + 16'(2 * i));
            fill_q.push_back('{port, i, base, mem_fn(base + 16'(2 * i))});
        end
    endtask

    // One clock: memory responses for this cycle, then scoreboard checks of the
    // default instance, then record this cycle's issues into the latency pipes.
    task automatic tick();
        fill_t       f;
        logic [31:0] exp_we;
        logic [31:0] exp_done;
        logic        due_next;
        @(posedge clk);
        #1;
        cyc++;
        mem_valid   = pv[cyc % 8];
        mem_rdata   = pv[cyc % 8] ? mem_fn(pa[cyc % 8]) : 16'h0000;
        pv[cyc % 8] = 1'b0;
        if (stray) begin
            mem_valid = 1'b1;
            mem_rdata = 16'hDEAD;
        end
        s_mem_valid = sv[cyc % 8];
        s_mem_rdata = sv[cyc % 8] ? mem_fn(sa[cyc % 8]) : 16'h0000;
        sv[cyc % 8] = 1'b0;
        #1;
        if (mem_rd === 1'b1) begin
            if (iss_q.size() == 0) check("mem_rd_unexpected", 32'd1, 32'd0);
            else check("mem_addr", {16'h0, mem_addr}, {16'h0, iss_q.pop_front()});
        end
        exp_we   = 32'd0;
        due_next = 1'b0;
        if (mem_valid && fill_q.size() > 0) begin
            f = fill_q.pop_front();
            exp_we = 32'd1 << f.port;
            check("fill_word", {29'h0, fill_word}, f.word);
            check("fill_data", {16'h0, fill_data}, {16'h0, f.data});
            check("fill_base", {16'h0, fill_base}, {16'h0, f.base});
            rcv_in_fill = (f.word == 0) ? 1 : rcv_in_fill + 1;
            if (f.word == 7) begin
                due_next  = 1'b1;
                done_port = f.port;
            end
        end
        check("fill_we", {30'h0, fill_we}, exp_we);
        exp_done = done_due ? (32'd1 << done_port) : 32'd0;
        check("fill_done", {30'h0, fill_done}, exp_done);
        check("stall", {30'h0, stall}, {30'h0, miss_req} & ~exp_done);
        done_due = due_next;
        if (mem_rd === 1'b1) begin
            pv[(cyc + 3) % 8] = 1'b1;
            pa[(cyc + 3) % 8] = mem_addr;
        end
        if (s_mem_rd === 1'b1) begin
            sv[(cyc + 1) % 8] = 1'b1;
            sa[(cyc + 1) % 8] = s_mem_addr;
        end
    endtask

    // Bounded wait for fill_done of a port; the requester drops its miss the
    // following cycle unless it is told to keep requesting.
    task automatic wait_done(input int port, input bit keep);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (fill_done[port] === 1'b1) seen = 1'b1;
        end
        check($sformatf("done_port%0d", port), {31'h0, seen}, 32'd1);
        if (!keep) miss_req[port] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sb;
        int          sw_w;
        int          sw_i;
        bit          seen;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0; pa[i] = '0; sv[i] = 1'b0; sa[i] = '0;
        end
        rst = 1'b1; stray = 1'b0; done_due = 1'b0; done_port = 0; rcv_in_fill = 0;
        miss_req = '0; miss_addr = '0; mem_valid = 1'b0; mem_rdata = '0;
        s_miss_req = '0; s_miss_addr = '0; s_mem_valid = 1'b0; s_mem_rdata = '0;
        repeat (3) tick();
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
        check("rst_fill_base", {16'h0, fill_base}, 32'd0);
        rst = 1'b0;
        tick();

        // Simultaneous pair right after reset: port 0, then port 1, twice.
        miss_addr = {16'h2A18, 16'h0456};
        miss_req  = 2'b11;
        push_block(0, 16'h0456);
        push_block(1, 16'h2A18);
        wait_done(0, 1'b0);
        wait_done(1, 1'b0);
        tick();
        miss_addr = {16'h6F0E, 16'h4001};
        miss_req  = 2'b11;
        push_block(0, 16'h4001);
        push_block(1, 16'h6F0E);
        wait_done(0, 1'b0);
        wait_done(1, 1'b0);
        tick();

        // Single miss on port 1 at 0x1234.
        miss_addr[16 +: 16] = 16'h1234;
        miss_req = 2'b10;
        push_block(1, 16'h1234);
        tick();
        tick();
        check("busy_in_fill", {31'h0, busy}, 32'd1);
        check("base_1230", {16'h0, fill_base}, 32'h1230);
        wait_done(1, 1'b0);
        check("stall1_at_done", {31'h0, stall[1]}, 32'd0);
        tick();
        check("busy_after_done", {31'h0, busy}, 32'd0);
        check("mem_addr_hold", {16'h0, mem_addr}, 32'h123E);

        // Port 0 keeps requesting after its DONE while port 1 waits: port 1 wins.
        miss_addr = {16'h3330, 16'h0100};
        miss_req  = 2'b01;
        push_block(0, 16'h0100);
        repeat (3) tick();
        miss_req[1] = 1'b1;
        push_block(1, 16'h3330);
        wait_done(0, 1'b1);
        push_block(0, 16'h0100);
        wait_done(1, 1'b0);
        wait_done(0, 1'b0);
        tick();

        // Granted port drops its request and changes address mid-fill.
        miss_addr[16 +: 16] = 16'h5552;
        miss_req = 2'b10;
        push_block(1, 16'h5552);
        repeat (4) tick();
        miss_req[1] = 1'b0;
        miss_addr[16 +: 16] = 16'hFFFF;
        wait_done(1, 1'b1);
        tick();

        // Reset after 3 of 8 words: aborted fill, in-flight data and a stray dropped.
        miss_addr[0 +: 16] = 16'h7770;
        miss_req = 2'b01;
        push_block(0, 16'h7770);
        rcv_in_fill = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (rcv_in_fill == 3) seen = 1'b1;
        end
        check("three_words", {31'h0, seen}, 32'd1);
        rst = 1'b1;
        miss_req = 2'b00;
        fill_q.delete();
        iss_q.delete();
        tick();
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_fill_base", {16'h0, fill_base}, 32'd0);
        check("abort_mem_addr", {16'h0, mem_addr}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (2) tick();
        check("iss_q_empty", iss_q.size(), 32'd0);
        check("fill_q_empty", fill_q.size(), 32'd0);

        // Sweep instance: 4 ports held high, 2-word blocks, latency 1.
        for (int p = 0; p < 4; p++) begin
            s_miss_addr[p*16 +: 16] = 16'h1001 + 16'(p * 16'h0102);
        end
        s_miss_req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            sb   = (16'h1001 + 16'(k * 16'h0102)) & 16'hFFFC;
            sw_w = 0;
            sw_i = 0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                check("s_stall", {28'h0, s_stall}, {28'h0, s_miss_req & ~s_fill_done});
                if (s_mem_rd === 1'b1) begin
                    check("s_mem_addr", {16'h0, s_mem_addr}, {16'h0, sb + 16'(2 * sw_i)});
                    sw_i++;
                end
                if (s_fill_we !== 4'h0) begin
                    check("s_fill_we", {28'h0, s_fill_we}, 32'd1 << k);
                    check("s_fill_word", {31'h0, s_fill_word}, sw_w);
                    check("s_fill_data", {16'h0, s_fill_data}, {16'h0, mem_fn(sb + 16'(2 * sw_w))});
                    check("s_fill_base", {16'h0, s_fill_base}, {16'h0, sb});
                    sw_w++;
                end
                if (s_fill_done !== 4'h0) begin
                    check("s_fill_done", {28'h0, s_fill_done}, 32'd1 << k);
                    seen = 1'b1;
                end
            end
            check($sformatf("s_done_%0d", k), {31'h0, seen}, 32'd1);
            check($sformatf("s_words_%0d", k), sw_w, 32'd2);
            check($sformatf("s_issues_%0d", k), sw_i, 32'd2);
        end
        s_miss_req = 4'h0;
        repeat (2) tick();
        check("s_idle", {31'h0, s_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
